// File: rtl/hazard_class_pipe.sv
// Instruction class decoder with Tuse/Tnew hazard tracking for a P6-class pipeline.
// Keeps NSTAGE in-flight writer slots after D and produces stall, forwarding
// selects and a saturating count of stalled cycles.
module hazard_class_pipe #(
  parameter int NSTAGE    = 3,
  parameter int TNEW_ALU  = 1,
  parameter int TNEW_LOAD = 2,
  parameter int CNT_W     = 16,
  localparam int FW       = $clog2(NSTAGE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_d,
  input  logic             d_valid,
  input  logic             flush,
  output logic [6:0]       cls_d,
  output logic             stall,
  output logic [FW-1:0]    fwd_rs,
  output logic [FW-1:0]    fwd_rt,
  output logic [CNT_W-1:0] stall_cnt
);

  // One-hot class bit positions, {NOP,J,B,SM,LM,RI,RR}
  localparam int C_RR  = 0;
  localparam int C_RI  = 1;
  localparam int C_LM  = 2;
  localparam int C_SM  = 3;
  localparam int C_B   = 4;
  localparam int C_J   = 5;
  localparam int C_NOP = 6;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_bits;

  assign opcode      = instr_d[31:26];
  assign rs          = instr_d[25:21];
  assign rt          = instr_d[20:16];
  assign rd          = instr_d[15:11];
  assign funct       = instr_d[5:0];
  assign unused_bits = ^instr_d[10:6];

  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [4:0] dec_dest;
  logic [1:0] dec_tnew;

  // Writer slots: index 0 is the youngest (E), NSTAGE-1 the oldest
  logic [NSTAGE-1:0][4:0] dest_q;
  logic [NSTAGE-1:0][1:0] tnew_q;

  // Decode class, source use times and the destination written by instr_d
  always_comb begin
    cls_d    = 7'd0;
    cls_d[C_NOP] = 1'b1;
    tuse_rs  = 2'd3;
    tuse_rt  = 2'd3;
    dec_dest = 5'd0;
    dec_tnew = 2'd0;
    if (d_valid) begin
      case (opcode)
        6'h00: begin
          case (funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B: begin
              cls_d    = 7'd1 << C_RR;
              tuse_rs  = 2'd1;
              tuse_rt  = 2'd1;
              dec_dest = rd;
              dec_tnew = 2'(TNEW_ALU);
            end
            6'h08: begin
              cls_d   = 7'd1 << C_J;
              tuse_rs = 2'd0;
            end
            default: ;
          endcase
        end
        6'h0D, 6'h0F, 6'h08, 6'h0C: begin
          cls_d    = 7'd1 << C_RI;
          tuse_rs  = 2'd1;
          dec_dest = rt;
          dec_tnew = 2'(TNEW_ALU);
        end
        6'h23, 6'h21, 6'h20: begin
          cls_d    = 7'd1 << C_LM;
          tuse_rs  = 2'd1;
          dec_dest = rt;
          dec_tnew = 2'(TNEW_LOAD);
        end
        6'h2B, 6'h29, 6'h28: begin
          cls_d   = 7'd1 << C_SM;
          tuse_rs = 2'd1;
          tuse_rt = 2'd2;
        end
        6'h04, 6'h05: begin
          cls_d   = 7'd1 << C_B;
          tuse_rs = 2'd0;
          tuse_rt = 2'd0;
        end
        6'h03: begin
          cls_d    = 7'd1 << C_J;
          dec_dest = 5'd31;
        end
        default: ;
      endcase
    end
  end

  // Returns {stall, fwd} for one source; the youngest matching slot decides,
  // so the scan runs oldest-to-youngest and lets later matches overwrite.
  function automatic logic [FW:0] check_src(input logic [4:0] src, input logic [1:0] tuse);
    logic          hit_stall;
    logic [FW-1:0] sel;
    hit_stall = 1'b0;
    sel       = '0;
    if (src != 5'd0 && tuse != 2'd3) begin
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (dest_q[k] == src) begin
          if (tnew_q[k] > tuse) begin
            hit_stall = 1'b1;
            sel       = '0;
          end else begin
            hit_stall = 1'b0;
            sel       = (tnew_q[k] == 2'd0) ? FW'(k + 1) : '0;
          end
        end
      end
    end
    return {hit_stall, sel};
  endfunction

  logic [FW:0] res_rs;
  logic [FW:0] res_rt;

  // Combine per-source results; forwarding is meaningless while stalled
  always_comb begin
    res_rs = check_src(rs, tuse_rs);
    res_rt = check_src(rt, tuse_rt);
    stall  = d_valid & (res_rs[FW] | res_rt[FW]);
    fwd_rs = stall ? '0 : res_rs[FW-1:0];
    fwd_rt = stall ? '0 : res_rt[FW-1:0];
  end

  // Advance writer slots; a stalled or flushed D contributes a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dest_q <= '0;
      tnew_q <= '0;
    end else begin
      dest_q[0] <= (stall || flush) ? 5'd0 : dec_dest;
      tnew_q[0] <= (stall || flush) ? 2'd0 : dec_tnew;
      for (int k = 1; k < NSTAGE; k++) begin
        dest_q[k] <= dest_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] == 2'd0) ? 2'd0 : tnew_q[k-1] - 2'd1;
      end
    end
  end

  // Count stalled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_class_pipe.md
Name: hazard_class_pipe

Overview:
- Parametrised successor to the single-cycle instruction type decoder.
- Decodes the D-stage instruction into class, source-use time (Tuse) and destination.
- Tracks in-flight writers through NSTAGE downstream pipeline slots, each holding a destination and a remaining-latency counter (Tnew).
- Produces the D-stage stall, per-source forwarding selects and a saturating stall-cycle counter for the P6-class pipeline.

Parameters:
- NSTAGE, 3, number of tracked slots after D (slot0=E, slot1=M, slot2=W); legal range 2..4.
- TNEW_ALU, 1, Tnew loaded into slot0 for RR/RI calc instructions.
- TNEW_LOAD, 2, Tnew loaded into slot0 for load instructions.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- instr_d  in  32  instruction currently in D.
- d_valid  in  1  instr_d is a real instruction; when 0 it is treated as NOP.
- flush  in  1  insert a bubble into slot0 at the next edge.
- cls_d  out  7  one-hot class of instr_d, bit order {NOP,J,B,SM,LM,RI,RR}.
- stall  out  1  freeze PC/F/D; the bubble is inserted into slot0 by this block.
- fwd_rs, fwd_rt  out  FW=$clog2(NSTAGE+1)  0=register file, k=slot k-1.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Decode (combinational):
  - RR = opcode 0 with funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sltu 101011.
  - RI = ori 001101, lui 001111, addi 001000, andi 001100.
  - LM = lw 100011, lh 100001, lb 100000.
  - SM = sw 101011, sh 101001, sb 101000.
  - B = beq 000100, bne 000101.
  - J = jal 000011, or jr (opcode 0, funct 001000).
  - NOP = instr_d==0, or d_valid==0, or any unlisted encoding.
  - Exactly one cls_d bit is set.
- Tuse (2 bits; value 3 means unused):
  - RR: rs 1, rt 1.
  - RI: rs 1, rt 3.
  - LM: rs 1, rt 3.
  - SM: rs 1, rt 2.
  - B: rs 0, rt 0.
  - jr: rs 0, rt 3.
  - jal and NOP: rs 3, rt 3.
- Destination and Tnew:
  - RR: dest rd, Tnew TNEW_ALU.
  - RI: dest rt, Tnew TNEW_ALU.
  - LM: dest rt, Tnew TNEW_LOAD.
  - jal: dest 31, Tnew 0.
  - All others: dest 0, Tnew 0.
- Slot state: dest[k] (5 bits) and tnew[k] (2 bits) for k=0..NSTAGE-1.
- Each rising edge:
  - slot k (k≥1) takes slot k-1 with tnew decremented, saturating at 0.
  - slot0 takes the decoded D entry, unless stall or flush, in which case it takes a bubble (dest 0, tnew 0).
  - The contents of slot NSTAGE-1 are discarded.
- Hazard check, done independently for rs and rt:
  - Skip when the source is $0 or its Tuse is 3.
  - Find the youngest (lowest k) slot with dest[k]==src.
  - If tnew[k] > Tuse, assert stall.
  - Else if tnew[k]==0, fwd = k+1.
  - Else fwd = 0.
  - With no match, fwd = 0.
  - Older matching slots are ignored once a younger match exists.
- stall is the OR of the rs and rt results. It is forced 0 when d_valid==0. fwd_* are forced to 0 whenever stall==1.
- stall_cnt increments at each edge where stall==1 and saturates at all-ones (no wrap).
- flush together with stall: a single bubble enters slot0, and the counter still increments.
- Reset low, at any time including mid-stall: all dest/tnew = 0 and stall_cnt = 0 immediately. stall and fwd_* then read 0 (given no slot matches). Decode outputs stay combinational on instr_d.
- Latency: decode, stall and fwd are combinational from instr_d and slot registers. Slot and counter updates occur one clock later.
- rs==rt case: both checks use the same slot, so stall/fwd results are consistent.

Test Plan:
1. Reset low → all slots clear, stall=0, stall_cnt=0. Decode add $3,$1,$2 → cls_d=0000001, fwd_rs=fwd_rt=0.
2. lw $5,0($1), then add $6,$5,$5 in D:
   - Cycle 1: slot0 tnew=2 > Tuse 1 → stall=1, stall_cnt 0→1.
   - Next cycle: slot1 tnew=1, still > Tuse 0? No, Tuse is 1, so 1 > 1 is false → stall=0, fwd_rs=fwd_rt=0 (tnew≠0).
   - One more cycle: slot2 tnew=0 → fwd=3.
3. ori $4,$0,5, then beq $4,$0 in D: slot0 tnew=1 > Tuse 0 → stall=1 for one cycle. Next cycle slot1 tnew=0 → stall=0, fwd_rs=2.
4. jal, then jr $31 in D: slot0 dest 31, tnew 0 → stall=0, fwd_rs=1.
5. addi $0,$1,1, then add $2,$0,$0: no stall, fwd=0. Also with d_valid=0 and a hazardous instr_d: stall=0, cls_d NOP bit set.
6. CNT_W=4 with 20 forced stall cycles → stall_cnt holds 15. Assert reset mid-stall → stall_cnt 0 and slots clear asynchronously, before the next edge.
